fp_func_sched: RTL and testbench

- Time-multiplexed scheduler for y = K_A*x + x^2*cos((x - K_C)*K_S) on IEEE-754 single-precision data.
- Owns shared arithmetic units through start/done ports: one multiplier, one add/sub, one float->cos->float chain.
- Provides a parametrised input FIFO, valid/ready in and out, a per-job mode select (cos term or bypass) and a watchdog that converts a hung unit into an error result.

---
 rtl/fp_func_pkg.sv | 29 ++
 rtl/fp_func_fifo.sv | 42 ++++
 rtl/fp_func_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fp_func_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_func_pkg.sv
// Shared constants, engine state encoding and unit-handshake helpers for the
// fp_func scheduler.
package fp_func_pkg;

  localparam logic [31:0] FP_NAN = 32'h7FC00000;
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_MUL_S,
    S_COS,
    S_MUL_P,
    S_MUL_H,
    S_ADD,
    S_HOLD
  } state_t;

  // States that own a unit: the first cycle fires go, later cycles wait on done.
  function automatic logic is_unit_state(input state_t s);
    return (s != S_IDLE) && (s != S_HOLD);
  endfunction

  // A done pulse only counts once the matching go has been issued.
  function automatic logic unit_fires(input logic issued, input logic done);
    return issued && done;
  endfunction

endpackage

// File: rtl/fp_func_fifo.sv
// Input FIFO for the scheduler: x plus mode bit, fall-through read so the
// engine can pop and capture in the same cycle.
module fp_func_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // The extra pointer bit separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp_func_sched.sv
// Time-multiplexed scheduler for y = K_A*x + x^2*cos((x-K_C)*K_S) driving
// shared mul, add/sub and cos units, with a watchdog that aborts hung jobs.
module fp_func_sched
  import fp_func_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] K_A     = 32'h3F000000,
  parameter logic [31:0] K_C     = 32'h43000000,
  parameter logic [31:0] K_S     = 32'h3C000000,
  parameter int          TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        busy,
  output logic        mul_go,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_res,
  output logic        add_go,
  output logic        add_sub,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_done,
  input  logic [31:0] add_res,
  output logic        cos_go,
  output logic [31:0] cos_in,
  input  logic        cos_done,
  input  logic [31:0] cos_res
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  state_t state_reg, state_next;
  logic   issued_reg, issued_next;
  logic   pop;
  logic   push;
  logic   fifo_full, fifo_empty;
  logic [32:0] fifo_data;

  logic [31:0] x_reg, t_reg, sq_reg, u_reg, c_reg, p_reg, h_reg, y_reg;
  logic        mode_reg, err_reg;
  logic        add_got_reg, mul_got_reg;
  logic [WDW-1:0] wd_reg;
  logic        rdy_en_reg;
  logic        out_valid_reg, out_err_reg;
  logic [31:0] out_data_reg;

  logic unit_state, go_now, waiting, step_done, accepted, timed_out, out_free;

  fp_func_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({in_mode, in_data}),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready   = rdy_en_reg && !fifo_full;
  assign push       = in_valid && in_ready;
  assign busy       = (state_reg != S_IDLE) || !fifo_empty;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_err    = out_err_reg;
  assign out_free   = !out_valid_reg || out_ready;

  assign unit_state = is_unit_state(state_reg);
  assign go_now     = unit_state && !issued_reg;
  assign waiting    = unit_state && issued_reg;

  // P1 waits on two units; either done may arrive first or both together.
  always_comb begin
    step_done = 1'b0;
    case (state_reg)
      S_P1:                     step_done = (add_got_reg || add_done) && (mul_got_reg || mul_done);
      S_MUL_S, S_MUL_P, S_MUL_H: step_done = mul_done;
      S_COS:                    step_done = cos_done;
      S_ADD:                    step_done = add_done;
      default:                  step_done = 1'b0;
    endcase
  end

  assign accepted  = unit_fires(waiting, step_done);
  assign timed_out = waiting && !step_done && (wd_reg == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      issued_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      issued_reg <= issued_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    issued_next = issued_reg;
    pop         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_next  = S_P1;
          issued_next = 1'b0;
        end
      end
      S_HOLD: begin
        if (out_free) state_next = S_IDLE;
      end
      default: begin
        if (go_now) begin
          issued_next = 1'b1;
        end else if (timed_out) begin
          state_next  = S_HOLD;
          issued_next = 1'b0;
        end else if (accepted) begin
          issued_next = 1'b0;
          case (state_reg)
            S_P1:    state_next = mode_reg ? S_MUL_H : S_MUL_S;
            S_MUL_S: state_next = S_COS;
            S_COS:   state_next = S_MUL_P;
            S_MUL_P: state_next = S_MUL_H;
            S_MUL_H: state_next = S_ADD;
            S_ADD:   state_next = out_free ? S_IDLE : S_HOLD;
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Operands are pure functions of state and captured registers, so they stay
  // stable for the whole go..done window.
  always_comb begin
    mul_go  = 1'b0;
    add_go  = 1'b0;
    cos_go  = 1'b0;
    mul_a   = x_reg;
    mul_b   = x_reg;
    add_sub = 1'b1;
    add_a   = x_reg;
    add_b   = K_C;
    cos_in  = u_reg;
    case (state_reg)
      S_P1: begin
        mul_go = go_now;
        add_go = go_now;
      end
      S_MUL_S: begin
        mul_go = go_now;
        mul_a  = t_reg;
        mul_b  = K_S;
      end
      S_COS: cos_go = go_now;
      S_MUL_P: begin
        mul_go = go_now;
        mul_a  = sq_reg;
        mul_b  = c_reg;
      end
      S_MUL_H: begin
        mul_go = go_now;
        mul_a  = K_A;
        mul_b  = x_reg;
      end
      S_ADD: begin
        add_go  = go_now;
        add_sub = 1'b0;
        add_a   = h_reg;
        add_b   = p_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg         <= '0;
      mode_reg      <= 1'b0;
      t_reg         <= '0;
      sq_reg        <= '0;
      u_reg         <= '0;
      c_reg         <= '0;
      p_reg         <= '0;
      h_reg         <= '0;
      y_reg         <= '0;
      err_reg       <= 1'b0;
      add_got_reg   <= 1'b0;
      mul_got_reg   <= 1'b0;
      wd_reg        <= '0;
      rdy_en_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;

      if (pop) begin
        x_reg    <= fifo_data[31:0];
        mode_reg <= fifo_data[32];
      end

      if (go_now)       wd_reg <= '0;
      else if (waiting) wd_reg <= wd_reg + WDW'(1);

      if (state_reg == S_P1) begin
        if (go_now) begin
          add_got_reg <= 1'b0;
          mul_got_reg <= 1'b0;
        end else begin
          if (add_done && !add_got_reg) begin
            t_reg       <= add_res;
            add_got_reg <= 1'b1;
          end
          if (mul_done && !mul_got_reg) begin
            sq_reg      <= mul_res;
            mul_got_reg <= 1'b1;
          end
        end
      end

      // Bypass mode skips the cos chain, so the square feeds the final add.
      if (state_reg == S_MUL_H && go_now && mode_reg) p_reg <= sq_reg;

      if (accepted) begin
        case (state_reg)
          S_MUL_S: u_reg <= mul_res;
          S_COS:   c_reg <= cos_res;
          S_MUL_P: p_reg <= mul_res;
          S_MUL_H: h_reg <= mul_res;
          S_ADD: begin
            y_reg   <= add_res;
            err_reg <= 1'b0;
          end
          default: ;
        endcase
      end

      if (timed_out) begin
        y_reg   <= FP_NAN;
        err_reg <= 1'b1;
      end

      if (state_reg == S_ADD && accepted && out_free) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= add_res;
        out_err_reg   <= 1'b0;
      end else if (state_reg == S_HOLD && out_free) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= y_reg;
        out_err_reg   <= err_reg;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_func_sched.sv
// Scoreboard bench for fp_func_sched with behavioural mul/add/cos units of
// programmable latency.
module tb_fp_func_sched;

  localparam logic [31:0] F_128  = 32'h43000000;
  localparam logic [31:0] F_2    = 32'h40000000;
  localparam logic [31:0] F_Y128 = 32'h46808000;
  localparam logic [31:0] F_Y2   = 32'h40A00000;
  localparam logic [31:0] F_NAN  = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_err, busy;
  logic [31:0] out_data;
  logic        mul_go, mul_done, add_go, add_sub, add_done, cos_go, cos_done;
  logic [31:0] mul_a, mul_b, mul_res, add_a, add_b, add_res, cos_in, cos_res;

  always #5 clk = ~clk;

  fp_func_sched #(
    .DEPTH(4), .K_A(32'h3F000000), .K_C(32'h43000000), .K_S(32'h3C000000), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy),
    .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_res(mul_res),
    .add_go(add_go), .add_sub(add_sub), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_res(add_res),
    .cos_go(cos_go), .cos_in(cos_in), .cos_done(cos_done), .cos_res(cos_res)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          push_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mul_lat = 1, add_lat = 1, cos_lat = 1;
  bit   cos_hang = 1'b0;
  int   inj_req = 0;
  int   cos_cnt = 0;

  logic [31:0] bx [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] by [8] = '{32'h3FC00000, 32'h40A00000, 32'h41280000, 32'h41900000,
                          32'h41DC0000, 32'h421C0000, 32'h42520000, 32'h42880000};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real sp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]);
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin r = r * 2.0; e--; end
    while (e < 127) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    real  a;
    int   e;
    int   mi;
    logic s;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mi = int'((a - 1.0) * 8388608.0);
    return {s, e[7:0], mi[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin : mul_model
    int cnt;
    logic [31:0] pend;
    cnt = 0; pend = '0; mul_done = 1'b0; mul_res = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mul_done = 1'b1; mul_res = pend; end
      end
      if (mul_go) begin
        pend = r2sp(sp2r(mul_a) * sp2r(mul_b));
        cnt  = mul_lat;
      end
    end
  end

  initial begin : add_model
    int cnt;
    logic [31:0] pend;
    cnt = 0; pend = '0; add_done = 1'b0; add_res = '0;
    forever begin
      @(negedge clk);
      add_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin add_done = 1'b1; add_res = pend; end
      end
      if (add_go) begin
        pend = add_sub ? r2sp(sp2r(add_a) - sp2r(add_b)) : r2sp(sp2r(add_a) + sp2r(add_b));
        cnt  = add_lat;
      end
    end
  end

  initial begin : cos_model
    int cnt;
    int inj_seen;
    logic [31:0] pend;
    cnt = 0; inj_seen = 0; pend = '0; cos_done = 1'b0; cos_res = '0;
    forever begin
      @(negedge clk);
      cos_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin cos_done = 1'b1; cos_res = pend; end
      end
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        cos_done = 1'b1;
        cos_res  = 32'h3F000000;
      end
      if (cos_go) begin
        cos_cnt++;
        if (!cos_hang) begin
          pend = r2sp($cos(sp2r(cos_in)));
          cnt  = cos_lat;
        end
      end
    end
  end

  initial begin : monitor
    int   first;
    exp_t e;
    first = -1;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        first = -1;
      end else if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", out_data);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_err", {31'd0, out_err}, {31'd0, e.err});
            if (e.lat >= 0) check("latency", 32'(first - e.push_cyc - 1), 32'(e.lat));
          end
          first = -1;
        end
      end
    end
  end

  task automatic push(input logic [31:0] x, input logic m, input logic [31:0] y,
                      input logic e, input int lat);
    int   n;
    exp_t ent;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=in_ready_low required=accept");
    end else begin
      ent.data = y; ent.err = e; ent.lat = lat; ent.push_cyc = cyc;
      sb.push_back(ent);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || out_valid) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy || out_valid) begin
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d busy=%b required_pending=0", sb.size(), busy);
    end
  endtask

  initial begin : watchdog_guard
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    int idx;
    int c0;
    int n;
    exp_t ent;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_go", {29'd0, mul_go, add_go, cos_go}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Full function, unit latency 1.
    push(F_128, 1'b0, F_Y128, 1'b0, 13);
    drain(200);

    // Bypass mode: no cos activity.
    c0 = cos_cnt;
    push(F_2, 1'b1, F_Y2, 1'b0, 7);
    drain(200);
    check("cos_go_mode1", 32'(cos_cnt - c0), 32'd0);

    // P1 done ordering: add before mul, then mul before add.
    mul_lat = 3;
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    drain(300);
    mul_lat = 1; add_lat = 3;
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    drain(300);
    add_lat = 1;

    // Backpressure: DEPTH + 2 accepted, then results in order.
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = bx[idx];
        in_mode  = 1'b1;
        if (in_ready) begin
          ent.data = by[idx]; ent.err = 1'b0; ent.lat = -1; ent.push_cyc = cyc;
          sb.push_back(ent);
          idx++;
        end
      end
    end
    in_valid = 1'b0;
    check("accepted_count", 32'(idx), 32'd6);
    check("in_ready_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    drain(600);

    // Hung cos unit -> watchdog error result, then recovery.
    cos_hang = 1'b1;
    push(F_128, 1'b0, F_NAN, 1'b1, -1);
    drain(3000);
    cos_hang = 1'b0;
    push(F_128, 1'b0, F_Y128, 1'b0, 13);
    drain(200);
    inj_req++;
    repeat (20) @(negedge clk);
    check("late_done_no_output", {31'd0, out_valid}, 32'd0);
    check("late_done_idle", {31'd0, busy}, 32'd0);
    push(F_2, 1'b1, F_Y2, 1'b0, 7);
    drain(200);

    // Reset in COS with three jobs queued.
    cos_lat = 4;
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    push(F_128, 1'b0, F_Y128, 1'b0, -1);
    c0 = cos_cnt;
    n = 0;
    while (cos_cnt == c0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_cos", {31'd0, cos_cnt != c0}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_go", {29'd0, mul_go, add_go, cos_go}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cos_lat = 1;
    repeat (6) @(negedge clk);
    check("midrst_fifo_empty", {31'd0, busy}, 32'd0);
    push(F_2, 1'b1, F_Y2, 1'b0, 7);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
